// File: rtl/pixel_write_arbiter_if.sv
// Request/write bundle between the DLA requesters, the arbiter and the framebuffer writer.
// Latency: none, wiring only.
// Backpressure: carries the iWr_Ready/oWr_Valid handshake and the per-channel one-cycle acks.
interface pixel_write_arbiter_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic [2:0]       iReq_Valid;
  logic [3*X_W-1:0] iReq_X;
  logic [3*Y_W-1:0] iReq_Y;
  logic [15:0]      iColor_Walker;
  logic [15:0]      iColor_Cluster;
  logic [2:0]       oReq_Ack;
  logic             oWr_Valid;
  logic             iWr_Ready;
  logic [X_W-1:0]   oWr_X;
  logic [Y_W-1:0]   oWr_Y;
  logic [15:0]      oWr_Color;
  logic [15:0]      oWr_Count;
  logic             oBusy;

  // Arbiter side
  modport slave (
    input  iReq_Valid, iReq_X, iReq_Y, iColor_Walker, iColor_Cluster, iWr_Ready,
    output oReq_Ack, oWr_Valid, oWr_X, oWr_Y, oWr_Color, oWr_Count, oBusy
  );

  // Requester / framebuffer side
  modport master (
    output iReq_Valid, iReq_X, iReq_Y, iColor_Walker, iColor_Cluster, iWr_Ready,
    input  oReq_Ack, oWr_Valid, oWr_X, oWr_Y, oWr_Color, oWr_Count, oBusy
  );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter sharing the framebuffer pixel-write port between erase, draw and stick channels.
// Latency: request seen in IDLE at cycle N -> oWr_Valid from N+1; ack in the acceptance cycle; one write per 2 cycles peak.
// Backpressure: oWr_* held stable while iWr_Ready=0; requesters stay pending until their ack.
module pixel_write_arbiter #(
  parameter int          X_W         = 10,
  parameter int          Y_W         = 9,
  parameter logic [15:0] ERASE_COLOR = 16'h0000
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  pixel_write_arbiter_if.slave bus
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     rr_q, rr_d;
  logic [1:0]     grant_q, grant_d;
  logic [X_W-1:0] wr_x_q, wr_x_d;
  logic [Y_W-1:0] wr_y_q, wr_y_d;
  logic [15:0]    wr_color_q, wr_color_d;
  logic [15:0]    wr_count_q, wr_count_d;

  logic           pick_vld;
  logic [1:0]     pick_ch;
  logic [X_W-1:0] pick_x;
  logic [Y_W-1:0] pick_y;
  logic [15:0]    pick_color;

  // Channel index modulo 3; inputs never exceed 4.
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // Round-robin search from the pointer: ptr, ptr+1, ptr+2; the lowest offset wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = rr_q;
    for (int k = 2; k >= 0; k--) begin
      if (bus.iReq_Valid[wrap3({1'b0, rr_q} + 3'(k))]) begin
        pick_vld = 1'b1;
        pick_ch  = wrap3({1'b0, rr_q} + 3'(k));
      end
    end
  end

  // Coordinate and colour of the candidate channel.
  always_comb begin
    pick_x     = bus.iReq_X[0 +: X_W];
    pick_y     = bus.iReq_Y[0 +: Y_W];
    pick_color = ERASE_COLOR;
    case (pick_ch)
      2'd1: begin
        pick_x     = bus.iReq_X[X_W +: X_W];
        pick_y     = bus.iReq_Y[Y_W +: Y_W];
        pick_color = bus.iColor_Walker;
      end
      2'd2: begin
        pick_x     = bus.iReq_X[2*X_W +: X_W];
        pick_y     = bus.iReq_Y[2*Y_W +: Y_W];
        pick_color = bus.iColor_Cluster;
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset drops any in-flight write.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= IDLE;
      rr_q       <= 2'd0;
      grant_q    <= 2'd0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_color_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_color_q <= wr_color_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Next state: latch the winner (colour included) in IDLE, retire it on acceptance in ISSUE.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_color_d = wr_color_q;
    wr_count_d = wr_count_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d    = pick_ch;
          wr_x_d     = pick_x;
          wr_y_d     = pick_y;
          wr_color_d = pick_color;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.iWr_Ready) begin
          wr_count_d = wr_count_q + 16'd1;
          rr_d       = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: valid/busy from state, ack combinational on the acceptance cycle.
  always_comb begin
    bus.oWr_Valid = (state_q == ISSUE);
    bus.oBusy     = (state_q == ISSUE);
    bus.oReq_Ack  = ((state_q == ISSUE) && bus.iWr_Ready) ? (3'b001 << grant_q) : 3'b000;
    bus.oWr_X     = wr_x_q;
    bus.oWr_Y     = wr_y_q;
    bus.oWr_Color = wr_color_q;
    bus.oWr_Count = wr_count_q;
  end

endmodule
